// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, driving the register file write port.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rg_wrt_en,
    output logic [REG_ADDR_W-1:0] rg_wrt_addr,
    output logic [XLEN-1:0]       rg_wrt_data
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [1:0]              op_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [XLEN-1:0]         quo;
    logic [XLEN-1:0]         rem;
    logic [XLEN-1:0]         divisor;
    logic [XLEN-1:0]         dividend_raw;
    logic                    neg_quo;
    logic                    neg_rem;
    logic                    div_zero;
    logic                    overflow;
`ifdef DIV_FAST_SPECIAL_EN
    logic                    fix_hold;
`endif

    logic                    rs1_neg;
    logic                    rs2_neg;
    logic [XLEN-1:0]         rs1_mag;
    logic [XLEN-1:0]         rs2_mag;
    logic                    in_div_zero;
    logic                    in_overflow;
    logic [XLEN:0]           shifted;
    logic [XLEN:0]           trial;
    logic [XLEN-1:0]         quo_fix;
    logic [XLEN-1:0]         rem_fix;
    logic [XLEN-1:0]         result;

    // Operand preparation: signed ops (op[0]=0) divide magnitudes and fix signs afterwards.
    always_comb begin
        rs1_neg     = ~op[0] & rs1_data[XLEN-1];
        rs2_neg     = ~op[0] & rs2_data[XLEN-1];
        rs1_mag     = rs1_neg ? (~rs1_data + 1'b1) : rs1_data;
        rs2_mag     = rs2_neg ? (~rs2_data + 1'b1) : rs2_data;
        in_div_zero = (rs2_data == '0);
        in_overflow = ~op[0] & (rs1_data == MOST_NEG) & (rs2_data == '1);
    end

    // One restoring step; the remainder stays below the divisor so XLEN bits hold it.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
    end

    always_comb begin
        quo_fix = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix = neg_rem ? (~rem + 1'b1) : rem;
        result  = op_q[1] ? rem_fix : quo_fix;
        if (div_zero) begin
            result = op_q[1] ? dividend_raw : '1;
        end else if (overflow) begin
            result = op_q[1] ? '0 : MOST_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            quo          <= '0;
            rem          <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rg_wrt_en    <= 1'b0;
            rg_wrt_addr  <= '0;
            rg_wrt_data  <= '0;
`ifdef DIV_FAST_SPECIAL_EN
            fix_hold     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q         <= op;
                        rd_q         <= rd_addr;
                        quo          <= rs1_mag;
                        rem          <= '0;
                        divisor      <= rs2_mag;
                        dividend_raw <= rs1_data;
                        neg_quo      <= rs1_neg ^ rs2_neg;
                        neg_rem      <= rs1_neg;
                        div_zero     <= in_div_zero;
                        overflow     <= in_overflow;
                        busy         <= 1'b1;
                        count        <= '0;
                        state        <= CALC;
`ifdef DIV_FAST_SPECIAL_EN
                        // The extra FIX cycle keeps the write two edges after start.
                        if (in_div_zero || in_overflow) begin
                            state    <= FIX;
                            fix_hold <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
`ifdef DIV_FAST_SPECIAL_EN
                    if (fix_hold) fix_hold <= 1'b0; else
`endif
                    begin
                        rg_wrt_data <= result;
                        rg_wrt_addr <= rd_q;
                        rg_wrt_en   <= (rd_q != '0);
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    rg_wrt_en <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
